// File: rtl/jf_pkg.sv
// rtl/jf_pkg.sv - shared constants and types for Jack's motion controller
package jf_pkg;

    localparam logic [7:0] KEY_W   = 8'h1D;
    localparam logic [7:0] KEY_A   = 8'h1C;
    localparam logic [7:0] KEY_D   = 8'h23;
    localparam logic [7:0] KEY_BRK = 8'hF0;
    localparam logic [7:0] KEY_EXT = 8'hE0;

    localparam int JACK_W     = 47;
    localparam int JACK_H     = 41;
    localparam int SCREEN_W   = 551;
    localparam int SCREEN_H   = 401;
    localparam int GROUND_ROW = 374;

    // Bit positions inside the held-key vector
    localparam int HELD_A = 0;
    localparam int HELD_D = 1;
    localparam int HELD_W = 2;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } motion_t;

endpackage

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - drains ps2 scan codes and tracks held A/D/W keys
module ps2_key_tracker
    import jf_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_ready,
    input  logic [7:0] ps2_data,
    output logic       ps2_rdn,
    output logic [2:0] held
);

    logic brk;
    logic ext;
    logic accept;

    // rdn high in the previous cycle doubles as "not busy", so no byte is read twice
    assign accept = ps2_ready && ps2_rdn;

    // Handshake strobe, prefix flags and make/break decode of the accepted byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2_rdn <= 1'b1;
            brk     <= 1'b0;
            ext     <= 1'b0;
            held    <= 3'b000;
        end else begin
            ps2_rdn <= !accept;
            if (accept) begin
                if (ps2_data == KEY_BRK) begin
                    brk <= 1'b1;
                end else if (ps2_data == KEY_EXT) begin
                    ext <= 1'b1;
                end else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    // Extended codes (arrows etc.) share base codes with letters; drop them
                    if (!ext) begin
                        case (ps2_data)
                            KEY_A:   held[HELD_A] <= !brk;
                            KEY_D:   held[HELD_D] <= !brk;
                            KEY_W:   held[HELD_W] <= !brk;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: rtl/jack_motion_ctrl.sv
// rtl/jack_motion_ctrl.sv - frame-tick physics for Jack's sprite position and state
module jack_motion_ctrl
    import jf_pkg::*;
#(
    parameter int FRAME_DIV = 1_666_666,
    parameter int X_MAX     = SCREEN_W - JACK_W,
    parameter int Y_FLOOR   = GROUND_ROW - JACK_H,
    parameter int X_INIT    = 0,
    parameter int STEP_X    = 2,
    parameter int JUMP_V0   = 12,
    parameter int GRAVITY   = 1,
    parameter int VY_MAX    = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_ready,
    input  logic [7:0] ps2_data,
    output logic       ps2_rdn,
    input  logic       game_run,
    output logic [9:0] x_blue,
    output logic [8:0] y_blue,
    output logic [2:0] blue_state,
    output logic       frame_tick
);

    localparam int CW = $clog2(FRAME_DIV + 1);

    localparam logic signed [10:0] STEP_S  = 11'(STEP_X);
    localparam logic signed [10:0] XMAX_S  = 11'(X_MAX);
    localparam logic signed [10:0] FLOOR_S = 11'(Y_FLOOR);
    localparam logic signed [10:0] V0_S    = 11'(JUMP_V0);
    localparam logic signed [10:0] GRAV_S  = 11'(GRAVITY);
    localparam logic signed [10:0] VMAX_S  = 11'(VY_MAX);

    logic [CW-1:0]     tick_cnt;
    logic [2:0]        held;
    motion_t           mstate;
    logic signed [10:0] vy;

    logic              go_left;
    logic              go_right;
    logic signed [10:0] x_cur;
    logic signed [10:0] x_nxt;
    logic signed [10:0] y_cur;
    logic signed [10:0] y_rise;
    logic signed [10:0] y_fall;
    logic signed [10:0] vy_dec;
    logic signed [10:0] vy_inc;

    ps2_key_tracker u_keys (
        .clk       (clk),
        .reset     (reset),
        .ps2_ready (ps2_ready),
        .ps2_data  (ps2_data),
        .ps2_rdn   (ps2_rdn),
        .held      (held)
    );

    assign frame_tick = (tick_cnt == CW'(FRAME_DIV - 1));

    // Free-running physics tick divider, independent of game_run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (frame_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Candidate next positions in signed 11-bit so clamps see the true sign
    always_comb begin
        go_left  = held[HELD_A] && !held[HELD_D];
        go_right = held[HELD_D] && !held[HELD_A];
        x_cur    = {1'b0, x_blue};
        x_nxt    = x_cur;
        if (go_left) begin
            x_nxt = x_cur - STEP_S;
            if (x_nxt < 11'sd0) x_nxt = 11'sd0;
        end else if (go_right) begin
            x_nxt = x_cur + STEP_S;
            if (x_nxt > XMAX_S) x_nxt = XMAX_S;
        end
        y_cur  = {2'b00, y_blue};
        vy_dec = vy - GRAV_S;
        y_rise = y_cur - vy;
        if (y_rise < 11'sd0) y_rise = 11'sd0;
        vy_inc = vy + GRAV_S;
        if (vy_inc > VMAX_S) vy_inc = VMAX_S;
        y_fall = y_cur + vy_inc;
    end

    // Motion FSM with registered position/state outputs, stepped once per running tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_blue     <= 10'(X_INIT);
            y_blue     <= 9'(Y_FLOOR);
            blue_state <= 3'b001;
            mstate     <= GROUND;
            vy         <= 11'sd0;
        end else if (frame_tick && game_run) begin
            x_blue <= 10'(x_nxt);
            if (go_left) begin
                blue_state[0] <= 1'b0;
            end else if (go_right) begin
                blue_state[0] <= 1'b1;
            end
            blue_state[2] <= (x_nxt != x_cur);
            case (mstate)
                GROUND: begin
                    y_blue <= 9'(Y_FLOOR);
                    if (held[HELD_W]) begin
                        mstate        <= RISE;
                        vy            <= V0_S;
                        blue_state[1] <= 1'b1;
                    end
                end
                RISE: begin
                    y_blue <= 9'(y_rise);
                    if (vy_dec <= 11'sd0 || y_rise == 11'sd0) begin
                        mstate <= FALL;
                        vy     <= 11'sd0;
                    end else begin
                        vy <= vy_dec;
                    end
                end
                FALL: begin
                    if (y_fall >= FLOOR_S) begin
                        y_blue        <= 9'(Y_FLOOR);
                        vy            <= 11'sd0;
                        mstate        <= GROUND;
                        blue_state[1] <= 1'b0;
                    end else begin
                        y_blue <= 9'(y_fall);
                        vy     <= vy_inc;
                    end
                end
                default: mstate <= GROUND;
            endcase
        end
    end

endmodule

// File: tb/tb_jack_motion_ctrl.sv
// tb/tb_jack_motion_ctrl.sv - scoreboard bench for jack_motion_ctrl
module tb_jack_motion_ctrl;

    localparam int FD   = 4;
    localparam int XM   = 504;
    localparam int YF   = 333;
    localparam int STEP = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_ready = 1'b0;
    logic [7:0] ps2_data = 8'h00;
    logic       game_run = 1'b0;
    logic       ps2_rdn;
    logic [9:0] x_blue;
    logic [8:0] y_blue;
    logic [2:0] blue_state;
    logic       frame_tick;

    always #5 clk = ~clk;

    jack_motion_ctrl #(.FRAME_DIV(FD)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_ready  (ps2_ready),
        .ps2_data   (ps2_data),
        .ps2_rdn    (ps2_rdn),
        .game_run   (game_run),
        .x_blue     (x_blue),
        .y_blue     (y_blue),
        .blue_state (blue_state),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [2:0] st;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] pend[$];
    int         traj[$];

    int n_checks = 0;
    int n_fail   = 0;

    bit held_a, held_d, held_w, brk_m, ext_m, rdn_m;
    bit face, mov, air;
    int cnt_m, mx, my, ai;
    bit rand_ready = 1'b0;
    int moved_ticks = 0;
    int min_y = 999;
    int air_ticks = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Whole jump as a list of per-tick heights, integrated from launch speed and gravity
    function automatic void build_traj();
        int y = YF;
        int v = 12;
        traj.delete();
        traj.push_back(YF);
        while (v > 0 && y > 0) begin
            y = (y - v < 0) ? 0 : y - v;
            v = v - 1;
            traj.push_back(y);
        end
        v = 0;
        do begin
            v = (v < 12) ? v + 1 : 12;
            y = (y + v >= YF) ? YF : y + v;
            traj.push_back(y);
        end while (y != YF);
    endfunction

    function automatic void model_reset();
        held_a = 0; held_d = 0; held_w = 0; brk_m = 0; ext_m = 0; rdn_m = 1;
        face = 1; mov = 0; air = 0;
        cnt_m = 0; mx = 0; my = YF; ai = -1;
        exp_q.delete(); rd_q.delete(); pend.delete();
    endfunction

    function automatic void model_tick();
        int nx = mx;
        if (held_a && !held_d) begin
            nx = (mx - STEP < 0) ? 0 : mx - STEP;
            face = 0;
        end else if (held_d && !held_a) begin
            nx = (mx + STEP > XM) ? XM : mx + STEP;
            face = 1;
        end
        mov = (nx != mx);
        mx  = nx;
        if (ai < 0 && held_w) ai = 0;
        else if (ai >= 0) ai++;
        if (ai >= 0) begin
            my  = traj[ai];
            air = (ai != traj.size() - 1);
            if (!air) ai = -1;
        end else begin
            my = YF;
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b == 8'hF0) brk_m = 1;
        else if (b == 8'hE0) ext_m = 1;
        else begin
            if (!ext_m) begin
                case (b)
                    8'h1C: held_a = !brk_m;
                    8'h23: held_d = !brk_m;
                    8'h1D: held_w = !brk_m;
                    default: ;
                endcase
            end
            brk_m = 0;
            ext_m = 0;
        end
    endfunction

    // One clock cycle: drive inputs, predict the coming edge, queue expectations
    task automatic step();
        bit tick, acc;
        ps2_ready = (pend.size() != 0) && (!rand_ready || ($urandom_range(0, 2) != 0));
        ps2_data  = (pend.size() != 0) ? pend[0] : 8'($urandom);
        tick = (cnt_m == FD - 1);
        acc  = ps2_ready && rdn_m;
        if (tick) begin
            if (game_run) begin
                model_tick();
                if (mov) moved_ticks++;
            end
            exp_q.push_back({10'(mx), 9'(my), mov, air, face});
        end
        if (acc) begin
            rd_q.push_back(ps2_data);
            model_byte(pend.pop_front());
        end
        rdn_m = !acc;
        cnt_m = tick ? 0 : cnt_m + 1;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Tick monitor: every DUT tick must match the next queued expectation
    initial begin : tick_mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && frame_tick) begin
                @(posedge clk);
                #1;
                check("tick_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("x_blue", x_blue, e.x);
                    check("y_blue", y_blue, e.y);
                    check("blue_state", blue_state, e.st);
                end
                if (y_blue < min_y) min_y = y_blue;
                if (blue_state[1]) air_ticks++;
            end
        end
    end

    // Read-strobe monitor: each pulse one cycle wide, one per accepted byte
    initial begin : rdn_mon
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (!ps2_rdn) check("rdn_during_reset", ps2_rdn, 1);
                prev = 1'b1;
            end else begin
                if (!ps2_rdn) begin
                    check("rdn_pulse_width", prev, 1);
                    check("rdn_byte_expected", int'(rd_q.size() > 0), 1);
                    if (rd_q.size() > 0) void'(rd_q.pop_front());
                end
                prev = ps2_rdn;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] tbl [8];
        int guard;
        tbl = '{8'h1C, 8'h23, 8'h1D, 8'hF0, 8'hE0, 8'h29, 8'h1C, 8'h23};
        build_traj();
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_x", x_blue, 0);
        check("reset_y", y_blue, YF);
        check("reset_state", blue_state, 3'b001);
        check("reset_rdn", ps2_rdn, 1);
        check("reset_tick", frame_tick, 0);
        reset = 1'b0;

        // Walk right for ten moving ticks, then release D
        game_run = 1'b1;
        pend.push_back(8'h23);
        guard = 0;
        while (moved_ticks < 10 && guard < 200) begin step(); guard++; end
        check("walk_timeout", int'(guard < 200), 1);
        pend.push_back(8'hF0); pend.push_back(8'h23);
        run(40);
        check("walk_x", x_blue, 20);
        check("walk_stopped", blue_state[2], 0);
        check("walk_facing", blue_state[0], 1);

        // Left clamp, then both keys, then right clamp
        pend.push_back(8'h1C);
        run(80);
        check("left_clamp_x", x_blue, 0);
        check("left_clamp_moving", blue_state[2], 0);
        check("left_facing", blue_state[0], 0);
        pend.push_back(8'h23);
        run(20);
        check("both_x", x_blue, 0);
        check("both_facing", blue_state[0], 0);
        pend.push_back(8'hF0); pend.push_back(8'h1C);
        run(1100);
        check("right_clamp_x", x_blue, XM);
        check("right_clamp_moving", blue_state[2], 0);
        pend.push_back(8'hF0); pend.push_back(8'h23);
        run(10);

        // Tap W: full jump regardless of the early release
        min_y = 999; air_ticks = 0;
        pend.push_back(8'h1D);
        guard = 0;
        while (ai < 0 && guard < 50) begin step(); guard++; end
        check("jump_timeout", int'(guard < 50), 1);
        pend.push_back(8'hF0); pend.push_back(8'h1D);
        run(130);
        check("jump_apex", min_y, 255);
        check("jump_airtime", air_ticks, 24);
        check("jump_landed_y", y_blue, YF);
        check("jump_landed_air", blue_state[1], 0);

        // Extended code with A's base code must not move Jack
        pend.push_back(8'hE0); pend.push_back(8'h1C);
        run(40);
        check("ext_x", x_blue, XM);

        // Frozen while not running, bytes still drained
        game_run = 1'b0;
        pend.push_back(8'h1C);
        run(40);
        check("frozen_x", x_blue, XM);
        check("frozen_drained", pend.size(), 0);
        pend.push_back(8'hF0); pend.push_back(8'h1C);
        run(10);
        game_run = 1'b1;

        // Randomized traffic
        rand_ready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (pend.size() == 0 && $urandom_range(0, 5) == 0)
                pend.push_back(tbl[$urandom_range(0, 7)]);
            if ($urandom_range(0, 199) == 0) game_run = !game_run;
            step();
        end
        rand_ready = 1'b0;
        game_run = 1'b1;
        pend.push_back(8'h29);
        pend.push_back(8'hF0); pend.push_back(8'h1C);
        pend.push_back(8'hF0); pend.push_back(8'h23);
        pend.push_back(8'hF0); pend.push_back(8'h1D);
        run(20);
        guard = 0;
        while (ai >= 0 && guard < 400) begin step(); guard++; end
        check("settle_timeout", int'(guard < 400), 1);

        // Asynchronous reset in the middle of a rise
        pend.push_back(8'h1D);
        guard = 0;
        while (!(ai >= 0 && my == 300) && guard < 200) begin step(); guard++; end
        check("rise_timeout", int'(guard < 200), 1);
        check("rise_y", y_blue, 300);
        #2;
        reset = 1'b1;
        ps2_ready = 1'b1;
        ps2_data = 8'h1C;
        #1;
        check("areset_y", y_blue, YF);
        check("areset_x", x_blue, 0);
        check("areset_state", blue_state, 3'b001);
        check("areset_rdn", ps2_rdn, 1);
        repeat (3) @(negedge clk);
        check("areset_rdn_held", ps2_rdn, 1);
        model_reset();
        ps2_ready = 1'b0;
        reset = 1'b0;
        run(60);
        check("after_reset_y", y_blue, YF);

        run(10);
        check("exp_q_empty", exp_q.size(), 0);
        check("rd_q_empty", rd_q.size(), 0);
        check("pend_empty", pend.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jack_motion_ctrl.md
Name: jack_motion_ctrl

Overview:
Player-motion controller for Jack. It drains scan codes from ps2_keyboard through its ready/rdn handshake and tracks held keys (make/break). On a frame tick it steps horizontal movement and a jump/gravity state machine. It drives x_blue, y_blue and blue_state to the sprite-address, detection and blue_show logic in top, replacing the per-keypress increment logic there.

Parameters:
FRAME_DIV, 1_666_666, clk cycles per physics tick (60 Hz at 100 MHz).
X_MAX, 504, rightmost legal x_blue (551 - 47 sprite width).
Y_FLOOR, 333, y_blue when standing on the ground row (374 - 41 sprite height).
X_INIT, 0, x_blue after reset.
STEP_X, 2, pixels moved per tick while A or D is held.
JUMP_V0, 12, initial upward speed in px/tick.
GRAVITY, 1, speed change per tick.
VY_MAX, 12, terminal fall speed.

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-high reset
ps2_ready  in  1  ps2_keyboard has a byte available
ps2_data  in  8  ps2_keyboard scan byte
ps2_rdn  out  1  read strobe to ps2_keyboard, active-low, 1-cycle pulse
game_run  in  1  game_state == 01; physics advances only when high
x_blue  out  10  sprite left x
y_blue  out  9  sprite top y
blue_state  out  3  [0] facing (0 left, 1 right), [1] airborne, [2] moving
frame_tick  out  1  1-cycle pulse per physics tick

Behaviour:
- Reset values: x_blue=X_INIT, y_blue=Y_FLOOR, blue_state=3'b001, ps2_rdn=1, frame_tick=0, FSM=GROUND, vy=0, held keys=0, break/extended flags=0, tick counter=0. Reset mid-jump returns to these values immediately because reset is asynchronous.
- Handshake: a byte is accepted when ps2_ready=1 and ps2_rdn was 1 in the previous cycle. In the accept cycle the byte is latched and ps2_rdn is driven 0 for exactly 1 cycle. This gives at most one byte per 2 cycles and never reads the same byte twice.
- Byte decode:
  - F0 sets brk.
  - E0 sets ext.
  - Any other byte: if ext=1, the byte is discarded. Otherwise held[key] = ~brk for A=1C, D=23, W=1D; other codes are ignored.
  - brk and ext clear after any non-prefix byte.
- Bytes are always consumed, including when game_run=0, so the keyboard FIFO never overflows.
- Tick: the counter counts 0..FRAME_DIV-1 and wraps. frame_tick=1 in the wrap cycle. The counter runs regardless of game_run.
- All physics updates happen only in cycles where frame_tick=1 and game_run=1. Otherwise all outputs hold.
- Horizontal, per tick:
  - Only A held: x = max(x - STEP_X, 0), blue_state[0]=0.
  - Only D held: x = min(x + STEP_X, X_MAX), blue_state[0]=1.
  - Both or neither held: no move, facing unchanged.
  - blue_state[2]=1 only if x actually changed this tick. Pushing against a clamp gives moving=0.
- Vertical FSM:
  - GROUND: if W held, go to RISE with vy=JUMP_V0 and blue_state[1]=1. Otherwise y=Y_FLOOR.
  - RISE: y = max(y - vy, 0) and vy = vy - GRAVITY. If the new vy ≤ 0 or y hit 0, go to FALL with vy=0.
  - FALL: vy = min(vy + GRAVITY, VY_MAX) and y = y + vy. If y + vy ≥ Y_FLOOR, then y=Y_FLOOR, vy=0, go to GROUND, blue_state[1]=0.
- While W stays held, GROUND re-jumps on the next tick after landing. Releasing W mid-air does not shorten the jump.
- Arithmetic is done in 11-bit signed intermediates so no underflow or overflow wraps. Results are clamped before truncation to 10/9 bits.
- A key event and a tick in the same cycle: the tick uses the held state from before the event; the event takes effect from the next tick.

Decomposition:
- Shared package jf_pkg holds:
  - scan-code constants KEY_W/KEY_A/KEY_D/KEY_BRK(F0)/KEY_EXT(E0);
  - motion FSM encoding GROUND/RISE/FALL;
  - sprite dimensions (JACK_W=47, JACK_H=41) and the screen size 551x401.
- One sub-module, ps2_key_tracker, owns the rdn handshake, prefix flags and held[2:0]. jack_motion_ctrl keeps the tick counter and physics.

Test Plan:
- FRAME_DIV=4, reset released: x=0, y=333, blue_state=001, ps2_rdn=1, frame_tick every 4th cycle.
- game_run=1. Bytes 23, then after 10 ticks F0,23: x reaches 20, blue_state[0]=1 and [2]=1 while moving. After the break, x holds at 20 and [2]=0. Each byte gives exactly one 1-cycle ps2_rdn pulse.
- Hold A from x=3: x goes 1, then 0, then stays 0 with moving=0. Hold A and D together: no movement.
- Press W, release after 1 tick:
  - y rises 321, 310, 300, … to apex 255 (vy counts 12→0);
  - it then falls and lands with y=333 exactly and blue_state[1]=0.
  - Total airtime is 24 ticks.
- Byte sequence E0,1C (extended key): no held state changes. game_run=0 with D held: position frozen, but bytes are still drained.
- Assert reset mid-RISE (y=300): y=333, FSM=GROUND, held=0 asynchronously. No ps2_rdn pulse while reset is high.
